// File: rtl/player_ctrl_param.sv
// player_ctrl_param: frame-driven player controller. It owns position, facing,
// sword placement and the idle animation. It consumes press/release pulses from
// the debouncer, latches them in a small buffer, and acts once per frame trigger.
module player_ctrl_param #(
   parameter int X_BITS          = 4,
   parameter int Y_BITS          = 4,
   parameter int X_MIN           = 0,
   parameter int X_MAX           = 15,
   parameter int Y_MIN           = 1,
   parameter int Y_MAX           = 11,
   parameter int START_X         = 1,
   parameter int START_Y         = 3,
   parameter int ATTACK_FRAMES   = 4,
   parameter int COOLDOWN_FRAMES = 2,
   parameter int REPEAT_FRAMES   = 6,
   parameter int ANIM_SPLIT      = 7,
   parameter int ANIM_PERIOD     = 21
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     trigger,
   input  logic [9:0]               input_data,
   input  logic                     respawn,
   output logic [X_BITS+Y_BITS-1:0] player_pos,
   output logic [1:0]               player_orientation,
   output logic [1:0]               player_direction,
   output logic [3:0]               player_sprite,
   output logic [X_BITS+Y_BITS-1:0] sword_position,
   output logic [3:0]               sword_visible,
   output logic [1:0]               sword_orientation,
   output logic                     busy
);

   localparam int PW = X_BITS + Y_BITS;

   localparam logic [X_BITS-1:0] X_LO  = X_BITS'(X_MIN);
   localparam logic [X_BITS-1:0] X_HI  = X_BITS'(X_MAX);
   localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
   localparam logic [Y_BITS-1:0] Y_LO  = Y_BITS'(Y_MIN);
   localparam logic [Y_BITS-1:0] Y_HI  = Y_BITS'(Y_MAX);
   localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);
   localparam logic [PW-1:0]     SPAWN = {X_BITS'(START_X), Y_BITS'(START_Y)};

   // Counters are compared against "last value" constants so that the
   // increment-and-compare happens on the value held before the trigger.
   localparam logic [15:0] ATK_LAST  = 16'(ATTACK_FRAMES - 1);
   localparam logic [15:0] CD_LAST   = 16'(COOLDOWN_FRAMES - 1);
   localparam logic [15:0] REP_LAST  = 16'(REPEAT_FRAMES - 1);
   localparam logic [15:0] ANIM_LAST = 16'(ANIM_PERIOD - 1);
   localparam logic [15:0] ANIM_MID  = 16'(ANIM_SPLIT);

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ATTACK   = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_pos;
   logic [1:0]    r_dir;
   logic [1:0]    r_orient;
   logic [3:0]    r_sprite;
   logic [PW-1:0] r_sword_pos;
   logic [3:0]    r_sword_vis;
   logic [1:0]    r_sword_ori;
   logic          r_busy;
   logic [4:0]    r_buf;
   logic          r_consumed;
   logic [15:0]   r_hold_cnt;
   logic [15:0]   r_atk_cnt;
   logic [15:0]   r_cd_cnt;
   logic [15:0]   r_anim_cnt;

   logic [X_BITS-1:0] w_x;
   logic [Y_BITS-1:0] w_y;
   logic [4:0]        w_press;
   logic [4:0]        w_release;
   logic              w_dir_held;
   logic [1:0]        w_res_dir;
   logic [X_BITS-1:0] w_adj_x;
   logic [Y_BITS-1:0] w_adj_y;
   logic              w_adj_ok;
   logic              w_start_atk;
   logic              w_fresh;
   logic              w_rep_tick;
   logic              w_step;

   assign w_x        = r_pos[PW-1:Y_BITS];
   assign w_y        = r_pos[Y_BITS-1:0];
   assign w_press    = input_data[9:5];
   assign w_release  = input_data[4:0];
   assign w_dir_held = |r_buf[3:0];

   // Resolve the buffered direction (right > left > down > up); with nothing
   // held the current facing is kept, which is also the attack direction then.
   always_comb begin
      w_res_dir = r_dir;
      if (r_buf[3])      w_res_dir = DIR_RIGHT;
      else if (r_buf[2]) w_res_dir = DIR_LEFT;
      else if (r_buf[1]) w_res_dir = DIR_DOWN;
      else if (r_buf[0]) w_res_dir = DIR_UP;
   end

   // Tile adjacent to the player in the resolved direction and whether it is
   // inside the legal grid; the raw tile wraps at the field width.
   always_comb begin
      w_adj_x  = w_x;
      w_adj_y  = w_y;
      w_adj_ok = 1'b0;
      case (w_res_dir)
         DIR_UP: begin
            w_adj_y  = w_y - Y_ONE;
            w_adj_ok = (w_y > Y_LO);
         end
         DIR_RIGHT: begin
            w_adj_x  = w_x + X_ONE;
            w_adj_ok = (w_x < X_HI);
         end
         DIR_DOWN: begin
            w_adj_y  = w_y + Y_ONE;
            w_adj_ok = (w_y < Y_HI);
         end
         default: begin
            w_adj_x  = w_x - X_ONE;
            w_adj_ok = (w_x > X_LO);
         end
      endcase
   end

   // Decide what a trigger does outside ATTACK: start an attack (IDLE only),
   // take a fresh press, or advance the hold-to-repeat counter.
   always_comb begin
      w_start_atk = 1'b0;
      w_fresh     = 1'b0;
      w_rep_tick  = 1'b0;
      w_step      = 1'b0;
      if (r_state != ST_ATTACK) begin
         if (r_buf[4] && !r_consumed && r_state == ST_IDLE) begin
            w_start_atk = 1'b1;
         end else if ((r_buf != 5'd0) && !r_consumed) begin
            w_fresh = 1'b1;
            w_step  = w_dir_held;
         end else if (w_dir_held && REPEAT_FRAMES != 0) begin
            w_rep_tick = 1'b1;
            w_step     = (r_hold_cnt == REP_LAST);
         end
      end
   end

   // Player FSM, sword and input buffer; the buffer update is written last so
   // a press in the same cycle as a trigger overrides consumed/hold_cnt.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_pos       <= SPAWN;
         r_dir       <= DIR_RIGHT;
         r_orient    <= 2'b01;
         r_sword_pos <= '0;
         r_sword_vis <= 4'b0000;
         r_sword_ori <= DIR_UP;
         r_busy      <= 1'b0;
         r_buf       <= 5'd0;
         r_consumed  <= 1'b0;
         r_hold_cnt  <= '0;
         r_atk_cnt   <= '0;
         r_cd_cnt    <= '0;
      end else if (respawn) begin
         r_state     <= ST_IDLE;
         r_pos       <= SPAWN;
         r_sword_pos <= '0;
         r_sword_vis <= 4'b0000;
         r_busy      <= 1'b0;
         r_buf       <= 5'd0;
         r_hold_cnt  <= '0;
         r_atk_cnt   <= '0;
         r_cd_cnt    <= '0;
      end else begin
         if (trigger) begin
            case (r_state)
               ST_ATTACK: begin
                  if (r_atk_cnt == ATK_LAST) begin
                     r_atk_cnt   <= '0;
                     r_cd_cnt    <= '0;
                     r_sword_vis <= 4'b0000;
                     r_sword_pos <= '0;
                     if (COOLDOWN_FRAMES != 0) begin
                        r_state <= ST_COOLDOWN;
                     end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_atk_cnt <= r_atk_cnt + 16'd1;
                  end
               end
               ST_COOLDOWN: begin
                  if (r_cd_cnt == CD_LAST) begin
                     r_cd_cnt <= '0;
                     r_state  <= ST_IDLE;
                     r_busy   <= 1'b0;
                  end else begin
                     r_cd_cnt <= r_cd_cnt + 16'd1;
                  end
               end
               default: ;
            endcase

            if (w_start_atk) begin
               r_dir       <= w_res_dir;
               r_sword_ori <= w_res_dir;
               r_sword_pos <= {w_adj_x, w_adj_y};
               r_sword_vis <= w_adj_ok ? 4'b0001 : 4'b0000;
               r_atk_cnt   <= '0;
               r_consumed  <= 1'b1;
               r_state     <= ST_ATTACK;
               r_busy      <= 1'b1;
            end

            if (w_fresh) begin
               r_consumed <= 1'b1;
            end

            if (w_rep_tick) begin
               r_hold_cnt <= w_step ? 16'd0 : r_hold_cnt + 16'd1;
            end

            if (w_step) begin
               r_dir <= w_res_dir;
               if (w_res_dir == DIR_RIGHT)     r_orient <= 2'b01;
               else if (w_res_dir == DIR_LEFT) r_orient <= 2'b11;
               if (w_adj_ok) r_pos <= {w_adj_x, w_adj_y};
            end
         end

         if (w_press != 5'd0) begin
            r_buf      <= w_press;
            r_consumed <= 1'b0;
            r_hold_cnt <= '0;
         end else if (w_release != 5'd0) begin
            r_buf      <= 5'd0;
            r_hold_cnt <= '0;
         end
      end
   end

   // Idle animation free-runs on every trigger, untouched by respawn.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_anim_cnt <= '0;
         r_sprite   <= 4'b0011;
      end else if (trigger) begin
         if (r_anim_cnt == ANIM_LAST) begin
            r_anim_cnt <= '0;
            r_sprite   <= 4'b0011;
         end else begin
            r_anim_cnt <= r_anim_cnt + 16'd1;
            if (r_anim_cnt == ANIM_MID) r_sprite <= 4'b0010;
         end
      end
   end

   assign player_pos         = r_pos;
   assign player_orientation = r_orient;
   assign player_direction   = r_dir;
   assign player_sprite      = r_sprite;
   assign sword_position     = r_sword_pos;
   assign sword_visible      = r_sword_vis;
   assign sword_orientation  = r_sword_ori;
   assign busy               = r_busy;

endmodule
